cla_nibble_sequencer: RTL and testbench

Multi-cycle wide adder controller. It time-shares a single `cla_4bit` slice across a `WIDTH`-bit operand pair, processing one nibble per clock from LSB to MSB. The block registers the inter-slice carry and accumulates the result. It sits between a valid/ready producer and a valid/ready consumer in area-constrained datapaths where a full-width CLA is too large.

---
 rtl/cla_nibble_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_cla_nibble_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cla_nibble_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cla_nibble_sequencer (with helper slice cla_4bit)
// Purpose  : Multi-cycle WIDTH-bit adder. A single 4-bit carry-lookahead
//            slice is reused once per nibble, LSB first. The carry between
//            passes is held in a register, and the result is built up one
//            nibble at a time. Valid/ready handshakes are used on both the
//            operand side and the result side.
// Options  : CLA_SEQ_FLAGS_EN - when defined, adds the registered signed
//            overflow (ovf) and zero-result (zero) outputs.
// Ports    : clk        - clock; all state changes on the rising edge
//            rst        - synchronous active-high reset
//            in_valid   - operand pair presented
//            in_ready   - operands can be accepted (IDLE only)
//            a, b, c_in - operands and carry-in, sampled on accept
//            out_valid  - result available (DONE)
//            out_ready  - consumer takes the result
//            sum, c_out - registered result and carry out of bit WIDTH-1
//            ovf, zero  - signed overflow / all-zero flags (option only)
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// 4-bit carry-lookahead slice. The block propagate/generate terms are left
// out because successive passes chain through the registered carry, so no
// second lookahead level ever consumes them.
// ----------------------------------------------------------------------------
module cla_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out
);
    logic [3:0] w_p;
    logic [3:0] w_g;
    logic [4:0] w_c;

    always_comb begin
        w_p    = a ^ b;
        w_g    = a & b;
        w_c[0] = c_in;
        w_c[1] = w_g[0] | (w_p[0] & c_in);
        w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & c_in);
        w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & c_in);
        w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
               | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & c_in);
        sum    = w_p ^ w_c[3:0];
        c_out  = w_c[4];
    end
endmodule

module cla_nibble_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef CLA_SEQ_FLAGS_EN
   ,output logic             ovf,
    output logic             zero
`endif
);
    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_sum;
    logic             r_c_out;

    logic             w_accept;
    logic             w_last;
    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;
    logic [3:0]       w_slice_sum;
    logic             w_slice_cout;

    // Nibble select: {idx,2'b00} is 4*idx without a 32-bit multiply.
    assign w_a_nib = r_a[{r_idx, 2'b00} +: 4];
    assign w_b_nib = r_b[{r_idx, 2'b00} +: 4];

    cla_4bit u_slice (
        .a     (w_a_nib),
        .b     (w_b_nib),
        .c_in  (r_carry),
        .sum   (w_slice_sum),
        .c_out (w_slice_cout)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and handshake outputs (decoded from state only)
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (r_idx == LAST_IDX) begin
                    w_last       = 1'b1;
                    w_state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_c_out <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= c_in;
            r_idx   <= '0;
        end else if (r_state == RUN) begin
            r_sum[{r_idx, 2'b00} +: 4] <= w_slice_sum;
            r_carry                    <= w_slice_cout;
            r_idx                      <= r_idx + IDX_ONE;
            if (w_last) begin
                r_c_out <= w_slice_cout;
            end
        end
    end

    assign sum   = r_sum;
    assign c_out = r_c_out;

`ifdef CLA_SEQ_FLAGS_EN
    logic r_ovf;
    logic r_zero;

    // Flags are formed on the DONE-entry edge. The top nibble is still on
    // the slice output at that point, so it is combined with the already
    // stored lower nibbles rather than read back from r_sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_last) begin
            r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                      (w_slice_sum[3] != r_a[WIDTH-1]);
            r_zero <= (w_slice_sum == 4'd0) && (r_sum[WIDTH-5:0] == '0);
        end
    end

    assign ovf  = r_ovf;
    assign zero = r_zero;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cla_nibble_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_nibble_sequencer
// Purpose  : Directed self-checking bench for cla_nibble_sequencer with
//            WIDTH=16, using hand-computed expected sums, carries and flags.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cla_nibble_sequencer;
    localparam int WIDTH = 16;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
`ifdef CLA_SEQ_FLAGS_EN
    logic             ovf;
    logic             zero;
`endif

    int checks   = 0;
    int failures = 0;

    cla_nibble_sequencer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out)
`ifdef CLA_SEQ_FLAGS_EN
       ,.ovf       (ovf),
        .zero      (zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for out_valid, returning the number of edges taken (-1 on timeout).
    task automatic wait_valid(output int n);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (out_valid) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                          input logic tc, input logic [15:0] esum, input logic ecout,
                          input logic eovf, input logic ezero);
        int lat;
        a = ta; b = tb_; c_in = tc; in_valid = 1'b1;
        step();                       // accept edge
        in_valid = 1'b0;
        a = '0; b = '0; c_in = 1'b0;  // operands must have been latched
        check({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
        wait_valid(lat);
        check({tag, "_latency"}, lat, 32'd4);
        check({tag, "_sum"}, {16'd0, sum}, {16'd0, esum});
        check({tag, "_cout"}, {31'd0, c_out}, {31'd0, ecout});
`ifdef CLA_SEQ_FLAGS_EN
        check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eovf});
        check({tag, "_zero"}, {31'd0, zero}, {31'd0, ezero});
`else
        if (eovf === 1'bx || ezero === 1'bx) check({tag, "_flagarg"}, 32'd1, 32'd0);
`endif
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
    endtask

    logic [15:0] s_a   [3];
    logic [15:0] s_b   [3];
    logic        s_c   [3];
    logic [15:0] s_sum [3];
    logic        s_co  [3];

    initial begin
        int lat;
        int seen;
        int acc_cyc [3];
        int na, nr, cyc;
        logic ir, ov;
        logic [15:0] smp_sum;
        logic smp_co;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; c_in = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_sum", {16'd0, sum}, 32'd0);
        check("rst_cout", {31'd0, c_out}, 32'd0);
`ifdef CLA_SEQ_FLAGS_EN
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd0);
`endif

        // Directed vectors
        run_op("v1234", 16'h1234, 16'h0FED, 1'b0, 16'h2221, 1'b0, 1'b0, 1'b0);
        run_op("ripple", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_op("posovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        run_op("negovf", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        run_op("mixed", 16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0, 1'b0, 1'b0);

        // Backpressure: DONE held, new operands offered but never consumed
        a = 16'h1111; b = 16'h2222; c_in = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_valid(lat);
        check("bp_latency", lat, 32'd4);
        for (int i = 0; i < 5; i++) begin
            a = 16'hFFFF; b = 16'hFFFF; c_in = 1'b1; in_valid = (i % 2) == 0;
            step();
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_sum", {16'd0, sum}, 32'h3333);
            check("bp_cout", {31'd0, c_out}, 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_release_valid", {31'd0, out_valid}, 32'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (out_valid || !in_ready) seen = 1;
        end
        check("bp_no_consume", seen, 32'd0);
        check("bp_sum_held", {16'd0, sum}, 32'h3333);

        // Reset during the second RUN cycle
        a = 16'h1234; b = 16'h0FED; c_in = 1'b0; in_valid = 1'b1;
        step();             // accept
        in_valid = 1'b0;
        step();             // first RUN edge done, now in second RUN cycle
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_sum", {16'd0, sum}, 32'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (out_valid) seen = 1;
        end
        check("mid_rst_no_result", seen, 32'd0);

        // Reset coincident with in_valid: operands not captured
        a = 16'h0F0F; b = 16'h0101; in_valid = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (out_valid || !in_ready) seen = 1;
        end
        check("rst_vs_valid", seen, 32'd0);

        // Streaming with in_valid/out_ready held high
        s_a[0] = 16'h0001; s_b[0] = 16'h0002; s_c[0] = 1'b0; s_sum[0] = 16'h0003; s_co[0] = 1'b0;
        s_a[1] = 16'hF0F0; s_b[1] = 16'h0F0F; s_c[1] = 1'b1; s_sum[1] = 16'h0000; s_co[1] = 1'b1;
        s_a[2] = 16'h8000; s_b[2] = 16'h7FFF; s_c[2] = 1'b0; s_sum[2] = 16'hFFFF; s_co[2] = 1'b0;
        na = 0; nr = 0; cyc = 0;
        acc_cyc[0] = 0; acc_cyc[1] = 0; acc_cyc[2] = 0;
        a = s_a[0]; b = s_b[0]; c_in = s_c[0];
        in_valid = 1'b1; out_ready = 1'b1;
        while ((na < 3 || nr < 3) && cyc < 60) begin
            ir = in_ready; ov = out_valid; smp_sum = sum; smp_co = c_out;
            step();
            cyc++;
            if (ir && in_valid) begin
                acc_cyc[na] = cyc;
                na++;
                if (na < 3) begin
                    a = s_a[na]; b = s_b[na]; c_in = s_c[na];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (ov) begin
                if (nr < 3) begin
                    check("stream_sum", {16'd0, smp_sum}, {16'd0, s_sum[nr]});
                    check("stream_cout", {31'd0, smp_co}, {31'd0, s_co[nr]});
                end
                nr++;
            end
        end
        out_ready = 1'b0;
        check("stream_accepts", na, 32'd3);
        check("stream_results", nr, 32'd3);
        check("stream_gap01", acc_cyc[1] - acc_cyc[0], 32'd6);
        check("stream_gap12", acc_cyc[2] - acc_cyc[1], 32'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
